// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus
// for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   z;
  logic             neg;

  modport master (
    output start,
    output x,
    output y,
    input  busy,
    input  done,
    input  z,
    input  neg
  );

  modport slave (
    input  start,
    input  x,
    input  y,
    output busy,
    output done,
    output z,
    output neg
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial z = x - y, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps negative results to zero.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   r_z;
  logic             r_neg;

  logic             w_a;
  logic             w_b;
  logic             w_w;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH:0]   w_z_fin;

  // full-subtractor cell plus next result word
  always_comb begin
    w_a    = r_a[0];
    w_b    = r_b[0];
    w_w    = r_borrow;
    w_d    = w_a ^ w_b ^ w_w;
    w_bout = (~w_a & w_b) | (~(w_a ^ w_b) & w_w);
    w_last = (r_cnt == CW'(WIDTH - 1));
    w_res_next = r_res >> 1;
    w_res_next[WIDTH-1] = w_d;
`ifdef SERIAL_SUB_SAT_EN
    w_z_fin = w_bout ? '0 : {w_bout, w_res_next};
`else
    w_z_fin = {w_bout, w_res_next};
`endif
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_z      <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.x;
            r_b      <= bus.y;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_z     <= w_z_fin;
            r_neg   <= w_bout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.z    = r_z;
  assign bus.neg  = r_neg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, hand sequences and random ops
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int ez;
    int en;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int ez, input int en);
`ifdef SERIAL_SUB_SAT_EN
    if (en != 0) return 0;
`endif
    return ez;
  endfunction

  // reference: plain modular subtraction
  task automatic model(input int x, input int y,
                       output int ez, output int en);
    en = (x < y) ? 1 : 0;
    ez = sat((x - y) & ((1 << (W + 1)) - 1), en);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // advance until done; lat = edges after the accepting edge
  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (bus.done === 1'b1) return;
      chk({nm, "_busy_run"}, 32'(bus.busy), 32'd1);
    end
    errors++;
    $display("FAIL %s_timeout: got no done expected done", nm);
  endtask

  task automatic run_op(input string nm, input int x, input int y,
                        input int ez, input int en);
    int lat;
    bus.start = 1'b1;
    bus.x = W'(x);
    bus.y = W'(y);
    step();
    bus.start = 1'b0;
    bus.x = W'($urandom);
    bus.y = W'($urandom);
    chk({nm, "_busy0"}, 32'(bus.busy), 32'd1);
    chk({nm, "_done0"}, 32'(bus.done), 32'd0);
    wait_done(nm, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(W));
    chk({nm, "_z"}, 32'(bus.z), 32'(ez));
    chk({nm, "_neg"}, 32'(bus.neg), 32'(en));
    chk({nm, "_busy_done"}, 32'(bus.busy), 32'd0);
    step();
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, "_z_hold"}, 32'(bus.z), 32'(ez));
  endtask

  initial begin
    int lat;
    int ez;
    int en;
    tv[0] = '{x: 9,  y: 3,  ez: 6,  en: 0};
    tv[1] = '{x: 3,  y: 9,  ez: 26, en: 1};
    tv[2] = '{x: 0,  y: 15, ez: 17, en: 1};
    tv[3] = '{x: 15, y: 0,  ez: 15, en: 0};
    tv[4] = '{x: 7,  y: 7,  ez: 0,  en: 0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_z", 32'(bus.z), 32'd0);
    chk("rst_neg", 32'(bus.neg), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      run_op($sformatf("vec%0d", i), tv[i].x, tv[i].y,
             sat(tv[i].ez, tv[i].en), tv[i].en);

    // start while busy must be ignored
    bus.start = 1'b1;
    bus.x = 4'd9;
    bus.y = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.x = 4'd1;
    bus.y = 4'd2;
    step();
    bus.start = 1'b0;
    lat = 2;
    for (int i = 0; i < 10 && bus.done !== 1'b1; i++) begin
      step();
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'(W));
    chk("ign_z", 32'(bus.z), 32'd6);
    chk("ign_neg", 32'(bus.neg), 32'd0);
    step();
    chk("ign_no_second", 32'(bus.busy), 32'd0);

    // back-to-back: start in the done cycle
    bus.start = 1'b1;
    bus.x = 4'd9;
    bus.y = 4'd3;
    step();
    bus.start = 1'b0;
    wait_done("b2b_a", lat);
    chk("b2b_a_z", 32'(bus.z), 32'd6);
    bus.start = 1'b1;
    bus.x = 4'd1;
    bus.y = 4'd2;
    step();
    bus.start = 1'b0;
    chk("b2b_b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b_b", lat);
    chk("b2b_b_lat", 32'(lat), 32'(W));
    chk("b2b_b_z", 32'(bus.z), 32'(sat(31, 1)));
    chk("b2b_b_neg", 32'(bus.neg), 32'd1);
    step();

    // load a nonzero result, then reset mid-run
    run_op("pre_rst", 15, 1, 14, 0);
    bus.start = 1'b1;
    bus.x = 4'd9;
    bus.y = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_z", 32'(bus.z), 32'd0);
    chk("arst_neg", 32'(bus.neg), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arst_nodone", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    run_op("post_rst", 9, 3, 6, 0);

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      int rx;
      int ry;
      rx = int'($urandom_range(0, (1 << W) - 1));
      ry = int'($urandom_range(0, (1 << W) - 1));
      model(rx, ry, ez, en);
      run_op($sformatf("rnd%0d_%0d_%0d", i, rx, ry), rx, ry, ez, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
